// File: rtl/dcache_core_tag_flush_pkg.sv
// Shared dcache definitions: tag RAM field layout, geometry, flush FSM
// state encoding and the line-address helper used by the flush engine.
package dcache_core_tag_flush_pkg;

    localparam int unsigned VALID_BIT = 20;
    localparam int unsigned DIRTY_BIT = 19;
    localparam int unsigned TAG_W     = 19;
    localparam int unsigned TAG_RAM_W = 21;
    localparam int unsigned SET_COUNT = 256;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned OFFSET_W  = 5;
    localparam int unsigned ADDR_W    = 32;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SET_COUNT - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_WB,
        ST_CLEAR
    } state_t;

    // Byte address of the first word of a cache line.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_core_tag_flush.sv
// Tag RAM initialise / flush engine for the data cache.
// After reset it zeroes all 256 tag entries; on a flush request it walks
// every set, issues a write-back for each valid+dirty line and clears it.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   flush_i           flush request (honoured only in IDLE, not on done cycle)
//   tag_addr0_o       tag RAM read index (port 0, 1-cycle read latency)
//   tag_data0_i       tag RAM read data {valid, dirty, tag[18:0]}
//   tag_addr1_o       tag RAM write index (port 1)
//   tag_data1_o       tag RAM write data (always zero)
//   tag_wr1_o         tag RAM write enable
//   wb_valid_o        write-back request, held until wb_accept_i
//   wb_addr_o         write-back line address
//   wb_accept_i       write-back accepted this cycle
//   busy_o            high in every state except IDLE
//   done_o            one-cycle pulse when a flush walk completes
module dcache_core_tag_flush
    import dcache_core_tag_flush_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [20:0] tag_data0_i,
    input  logic        wb_accept_i,
    output logic [7:0]  tag_addr0_o,
    output logic [7:0]  tag_addr1_o,
    output logic [20:0] tag_data1_o,
    output logic        tag_wr1_o,
    output logic        wb_valid_o,
    output logic [31:0] wb_addr_o,
    output logic        busy_o,
    output logic        done_o
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               wr_q, wr_d;
    logic               wbv_q, wbv_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        done_d  = 1'b0;
        unique case (state_q)
            // The first INIT cycle after reset release only raises the
            // registered write strobe; idx advances once a write is on the bus.
            ST_INIT: begin
                if (wr_q) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            // done_q marks the completion cycle, where flush_i is ignored.
            ST_IDLE: begin
                if (flush_i && !done_q) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (tag_data0_i[VALID_BIT] && tag_data0_i[DIRTY_BIT]) begin
                    tag_d   = tag_data0_i[TAG_W-1:0];
                    state_d = ST_WB;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_WB: begin
                if (wb_accept_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
    end

    // Output strobes are registered from the next state so they line up
    // with the state they belong to.
    assign wr_d  = (state_d == ST_INIT) || (state_d == ST_CLEAR);
    assign wbv_d = (state_d == ST_WB);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            tag_q   <= '0;
            wr_q    <= 1'b0;
            wbv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            wr_q    <= wr_d;
            wbv_q   <= wbv_d;
            done_q  <= done_d;
        end
    end

    assign tag_addr0_o = idx_q;
    assign tag_addr1_o = idx_q;
    assign tag_data1_o = '0;
    assign tag_wr1_o   = wr_q;
    assign wb_valid_o  = wbv_q;
    assign wb_addr_o   = line_addr(tag_q, idx_q);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;

endmodule
